// File: rtl/lc4_arith_seq.sv
// rtl/lc4_arith_seq.sv - multi-cycle LC4 arithmetic unit with valid/ready handshake on both sides
// Optional feature macro: LC4_ARITH_FAST_MUL_EN (single-cycle combinational MUL instead of shift-add).
module lc4_arith_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_MUL   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_ADDI5 = 3'd5;
  localparam logic [2:0] OP_ADDI6 = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             b_zero;
  logic             is_iter;
  logic             cnt_last;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] single_result;
  logic [WIDTH-1:0] step_opa, step_opb, step_rem;
  logic [WIDTH-1:0] step_result;
  logic [WIDTH:0]   rem_shift, rem_diff;

  assign accept   = i_valid && o_ready;
  assign b_zero   = (i_b == '0);
  assign cnt_last = (cnt_q == CW'(WIDTH - 1));

`ifdef LC4_ARITH_FAST_MUL_EN
  logic [WIDTH-1:0] mul_lo;
  assign mul_lo  = i_a * i_b;
  assign is_iter = (i_op == OP_DIV || i_op == OP_MOD) && !b_zero;
`else
  assign is_iter = ((i_op == OP_DIV || i_op == OP_MOD) && !b_zero) || (i_op == OP_MUL);
`endif

  // Shared adder: SUB is A + ~B + 1, the immediates are sign-extended from the low bits of B.
  always_comb begin
    add_b   = i_b;
    add_cin = 1'b0;
    case (i_op)
      OP_SUB: begin
        add_b   = ~i_b;
        add_cin = 1'b1;
      end
      OP_ADDI5: add_b = {{(WIDTH-5){i_b[4]}}, i_b[4:0]};
      OP_ADDI6: add_b = {{(WIDTH-6){i_b[5]}}, i_b[5:0]};
      default:  add_b = i_b;
    endcase
    add_sum = i_a + add_b + {{(WIDTH-1){1'b0}}, add_cin};
  end

  // Divide-by-zero and the reserved opcode both fall through to zero.
  always_comb begin
    single_result = '0;
    case (i_op)
      OP_ADD, OP_SUB, OP_ADDI5, OP_ADDI6: single_result = add_sum;
`ifdef LC4_ARITH_FAST_MUL_EN
      OP_MUL: single_result = mul_lo;
`endif
      default: single_result = '0;
    endcase
  end

  // One iteration: restoring divide step for DIV/MOD, shift-add step for MUL.
  always_comb begin
    rem_shift = {rem_q, opa_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    step_opa  = opa_q;
    step_opb  = opb_q;
    step_rem  = rem_q;
    if (op_q == OP_MUL) begin
      step_rem = opb_q[0] ? (rem_q + opa_q) : rem_q;
      step_opa = {opa_q[WIDTH-2:0], 1'b0};
      step_opb = {1'b0, opb_q[WIDTH-1:1]};
    end else begin
      step_opa = {opa_q[WIDTH-2:0], ~rem_diff[WIDTH]};
      step_rem = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    end
    step_result = (op_q == OP_DIV) ? step_opa : step_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_iter ? S_CALC : S_DONE;
      S_CALC: if (cnt_last) state_d = S_DONE;
      S_DONE: if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == S_IDLE);
    o_valid = (state_q == S_DONE);
    o_busy  = (state_q == S_CALC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= i_op;
            cnt_q <= '0;
            if (is_iter) begin
              opa_q <= i_a;
              opb_q <= i_b;
              rem_q <= '0;
            end else begin
              result_q <= single_result;
            end
          end
        end
        S_CALC: begin
          opa_q <= step_opa;
          opb_q <= step_opb;
          rem_q <= step_rem;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_last) result_q <= step_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_lc4_arith_seq.sv
// tb/tb_lc4_arith_seq.sv - directed table-driven bench for lc4_arith_seq (WIDTH=16)
module tb_lc4_arith_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'd0;
  logic [15:0] i_a = 16'd0;
  logic [15:0] i_b = 16'd0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_result;
  logic        o_busy;

  int checks = 0;
  int failures = 0;

`ifdef LC4_ARITH_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 17;
`endif

  lc4_arith_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the result retired.
  task automatic run_vec(input vec_t v);
    int cyc;
    int busy_cnt;
    i_op = v.op;
    i_a = v.a;
    i_b = v.b;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_a = 16'($urandom);
    i_b = 16'($urandom);
    i_op = 3'($urandom);
    cyc = 1;
    busy_cnt = 0;
    while (!o_valid && cyc < 100) begin
      if (o_busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({v.name, "_valid"}, 32'(o_valid), 32'd1);
    check({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
    check({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'(v.lat - 1));
    check({v.name, "_result"}, 32'(o_result), 32'(v.exp));
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({v.name, "_retired"}, 32'(o_valid), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add_ovf",   3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1});
    vecs.push_back('{"sub_wrap",  3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1});
    vecs.push_back('{"sub_small", 3'd2, 16'h0005, 16'h0003, 16'h0002, 1});
    vecs.push_back('{"imm5_neg",  3'd5, 16'h0010, 16'hFFF0, 16'h0000, 1});
    vecs.push_back('{"imm5_pos",  3'd5, 16'h0010, 16'h000F, 16'h001F, 1});
    vecs.push_back('{"imm6_neg",  3'd6, 16'h0010, 16'hFFF0, 16'h0000, 1});
    vecs.push_back('{"imm6_pos",  3'd6, 16'h0010, 16'h001F, 16'h002F, 1});
    vecs.push_back('{"div_100_7", 3'd3, 16'h0064, 16'h0007, 16'h000E, 17});
    vecs.push_back('{"mod_100_7", 3'd4, 16'h0064, 16'h0007, 16'h0002, 17});
    vecs.push_back('{"div_max",   3'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 17});
    vecs.push_back('{"mod_max",   3'd4, 16'hFFFF, 16'h0010, 16'h000F, 17});
    vecs.push_back('{"div_zero",  3'd3, 16'h0064, 16'h0000, 16'h0000, 1});
    vecs.push_back('{"mod_zero",  3'd4, 16'h0064, 16'h0000, 16'h0000, 1});
    vecs.push_back('{"mul_lo",    3'd1, 16'h0100, 16'h0101, 16'h0100, MUL_LAT});
    vecs.push_back('{"mul_max",   3'd1, 16'hFFFF, 16'hFFFF, 16'h0001, MUL_LAT});
    vecs.push_back('{"reserved",  3'd7, 16'h1234, 16'h5678, 16'h0000, 1});

    #2;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result must hold and nothing new may be accepted while DONE.
    i_op = 3'd0; i_a = 16'd1; i_b = 16'd2; i_valid = 1'b1;
    @(negedge clk);
    i_a = 16'd4; i_b = 16'd5;
    check("bp_valid", 32'(o_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_result", 32'(o_result), 32'd3);
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_ready", 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("bp_retire_valid", 32'(o_valid), 32'd0);
    check("bp_retire_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    check("bp_next_valid", 32'(o_valid), 32'd1);
    check("bp_next_result", 32'(o_result), 32'd9);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;

    // Reset in the middle of a divide.
    i_op = 3'd3; i_a = 16'h0064; i_b = 16'h0007; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    for (int k = 1; k < 8; k++) @(negedge clk);
    check("rstmid_busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(o_busy), 32'd0);
    check("rstmid_valid", 32'(o_valid), 32'd0);
    check("rstmid_result", 32'(o_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_ready", 32'(o_ready), 32'd1);
    check("rstmid_no_valid", 32'(o_valid), 32'd0);
    run_vec(vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/lc4_arith_seq.md
# lc4_arith_seq

Parametrised, multi-cycle successor to the combinational LC4 arithmetic unit. It executes ADD, MUL, SUB, DIV, MOD, ADDIMM5 and ADDIMM6 on WIDTH-bit operands. DIV and MOD use an iterative restoring divider, and MUL optionally uses a shift-add multiplier. The block sits behind the decode stage with a valid/ready handshake on both sides and produces one registered result per accepted operation.

## Interface
- WIDTH, 16, operand/result width; legal range 8..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operation request.
- o_ready  output  1  block can accept a request (high only in IDLE).
- i_op  input  3  0=ADD, 1=MUL, 2=SUB, 3=DIV, 4=MOD, 5=ADDIMM5, 6=ADDIMM6, 7=reserved.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B (immediate in low bits for ops 5/6).
- o_valid  output  1  o_result holds a completed result.
- i_ready  input  1  consumer accepts the result.
- o_result  output  WIDTH  registered result.
- o_busy  output  1  iterative operation in progress (DIV, MOD, or MUL when iterative).

## Operation
- Accept on the rising edge where i_valid && o_ready. Latch i_op, i_a and i_b; later changes to the inputs are ignored.
- States:
  - IDLE: o_ready=1.
  - CALC: iterative op; counter runs 0..WIDTH-1.
  - DONE: o_valid=1, o_ready=0.
- Transitions:
  - IDLE→DONE for single-cycle ops.
  - IDLE→CALC for iterative ops.
  - CALC→DONE when the counter reaches WIDTH-1.
  - DONE→IDLE on i_ready.
- No new operation is accepted while in DONE, including in the cycle where i_ready retires the result. The next accept is possible one cycle later.
- ADD: A+B mod 2^WIDTH.
- SUB: A+~B+1 mod 2^WIDTH, computed on the shared adder with carry-in 1.
- ADDIMM5: A + sign-extended B[4:0].
- ADDIMM6: A + sign-extended B[5:0].
- MUL: low WIDTH bits of the unsigned product.
- DIV/MOD: unsigned quotient/remainder. Each CALC cycle performs one restoring step: shift remainder left, bring in the next dividend MSB, subtract the divisor if it is not larger.
- Divide by zero (B==0 for DIV/MOD): result 0; skips CALC and takes the single-cycle path.
- i_op=7: result 0, single-cycle path.
- Carries and overflow are discarded; no flags are produced.

## Timing
- Reset values: state IDLE, o_ready=1, o_valid=0, o_busy=0, o_result=0, counter=0.
- Reset asserted mid-operation aborts it immediately. No result is produced and the block returns to IDLE.
- Single-cycle ops: accepted at edge N, o_valid=1 after edge N+1.
- Iterative ops: accepted at edge N, o_busy=1 from N through N+WIDTH, o_valid=1 after edge N+WIDTH+1. For WIDTH=16 this is 17 cycles.
- o_result and o_valid are held stable while i_ready=0, for any number of cycles.
- o_valid falls on the edge where i_ready=1 is sampled.
- o_busy=1 exactly while state==CALC.

## Configuration
- LC4_ARITH_FAST_MUL_EN defined: MUL uses a combinational WIDTH×WIDTH multiplier and takes the single-cycle path (IDLE→DONE).
- LC4_ARITH_FAST_MUL_EN undefined: MUL uses an iterative shift-add datapath, one multiplier bit per CALC cycle. It has the same latency as DIV and shares the CALC counter.
- All other behaviour is identical in both builds.

## Test plan
- ADD/SUB, WIDTH=16:
  - A=0x7FFF, B=0x0001, op 0 → 0x8000 one cycle after accept.
  - A=0x0000, B=0x0001, op 2 → 0xFFFF.
- ADDIMM: A=0x0010, B=0xFFF0, op 5 → 0x0000 (imm5=-16). Same inputs with op 6 → 0x0000 (imm6=-16). A=0x0010, B=0x001F, op 6 → 0x002F.
- DIV/MOD, A=0x0064 (100), B=0x0007:
  - op 3 → 0x000E, o_busy high for 16 cycles, o_valid on cycle 17.
  - op 4 → 0x0002.
  - B=0 → 0x0000 after 1 cycle, o_busy never asserted.
- MUL, A=0x0100, B=0x0101, op 1 → 0x0100 (low 16 bits). Latency is 1 cycle with LC4_ARITH_FAST_MUL_EN and 17 cycles without.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid. o_result stays constant, and o_ready stays 0 while i_valid is held high. After i_ready=1, the next request is accepted one cycle later.
- Reset mid-DIV: deassert rst_n at cycle 8 of CALC. o_busy, o_valid and o_result go to 0 immediately, and o_ready=1 after reset release.
